// File: rtl/led_band_pkg.sv
// Shared state encoding and command rise counts for the LED-band LAT sequencer.
package led_band_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FC_EN,
    FC_DATA,
    FC_WR,
    GS_DATA,
    GS_LAT
  } seq_state_e;

  localparam logic [5:0] FCWRTEN_RISES = 6'd15;
  localparam logic [5:0] WRTFC_RISES   = 6'd5;
  localparam logic [5:0] WRTGS_RISES   = 6'd1;
  localparam logic [5:0] LATGS_RISES   = 6'd3;
  localparam logic [5:0] WORD_BITS     = 6'd48;

  // FC data phase plus WRTFC must add up to one full 48-rise word.
  localparam logic [5:0] FC_DATA_RISES = WORD_BITS - WRTFC_RISES;

  function automatic logic [5:0] gs_data_rises(input logic last_word);
    return last_word ? (WORD_BITS - LATGS_RISES) : (WORD_BITS - WRTGS_RISES);
  endfunction

  function automatic logic [5:0] gs_lat_rises(input logic last_word);
    return last_word ? LATGS_RISES : WRTGS_RISES;
  endfunction

endpackage

// File: rtl/led_band_sclk_gen.sv
// SCLK divider: toggles every SCLK_DIV clk while run_i is high, held low otherwise.
// rise_o/fall_o flag the clk cycle at whose end SCLK goes 0->1 / 1->0.
module led_band_sclk_gen #(
  parameter int unsigned SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] RELOAD = 8'(SCLK_DIV - 1);

  logic [7:0] div_cnt_q;
  logic       sclk_q;
  logic       tc;

  assign tc     = run_i && (div_cnt_q == 8'd0);
  assign rise_o = tc && !sclk_q;
  assign fall_o = tc && sclk_q;
  assign sclk_o = sclk_q;

  always_ff @(posedge clk) begin
    if (rst || !run_i) begin
      div_cnt_q <= RELOAD;
      sclk_q    <= 1'b0;
    end else if (tc) begin
      div_cnt_q <= RELOAD;
      sclk_q    <= ~sclk_q;
    end else begin
      div_cnt_q <= div_cnt_q - 8'd1;
    end
  end

endmodule

// File: rtl/led_band_lat_sequencer.sv
// SCLK/LAT command sequencer for a TLC5957-style chain (FCWRTEN/WRTFC, WRTGS/LATGS).
// Build option LED_SEQ_AUTO_FC_EN: reset leaves an FC write pending.
//   state   | meaning
//   IDLE    | SCLK low, arbitrating pending requests (FC wins)
//   FC_EN   | LAT high, FCWRTEN
//   FC_DATA | LAT low, FC data bits
//   FC_WR   | LAT high, WRTFC
//   GS_DATA | LAT low, GS word bits
//   GS_LAT  | LAT high, WRTGS (or LATGS on the last word)
module led_band_lat_sequencer
  import led_band_pkg::*;
#(
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned N_WORDS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fc_req,
  input  logic       frame_start,
  output logic       SCLK,
  output logic       LAT,
  output logic       busy,
  output logic       gs_shift_en,
  output logic [3:0] gs_word_idx,
  output logic [5:0] gs_bit_idx,
  output logic       fc_done,
  output logic       frame_done
);

  localparam logic [3:0] LAST_WORD = 4'(N_WORDS - 1);
`ifdef LED_SEQ_AUTO_FC_EN
  localparam logic FC_PEND_RST = 1'b1;
`else
  localparam logic FC_PEND_RST = 1'b0;
`endif

  seq_state_e state_q;
  logic       lat_q, fc_done_q, frame_done_q, fc_pend_q, gs_pend_q;
  logic [3:0] word_q;
  logic [5:0] bit_q, rise_cnt_q, target;
  logic       run, sclk_rise, sclk_fall, last_word, seg_done;

  led_band_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk   (clk),
    .rst   (rst),
    .run_i (run),
    .sclk_o(SCLK),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  assign run       = (state_q != IDLE);
  assign last_word = (word_q == LAST_WORD);

  always_comb begin
    target = '0;
    case (state_q)
      FC_EN:   target = FCWRTEN_RISES;
      FC_DATA: target = FC_DATA_RISES;
      FC_WR:   target = WRTFC_RISES;
      GS_DATA: target = gs_data_rises(last_word);
      GS_LAT:  target = gs_lat_rises(last_word);
      default: target = '0;
    endcase
  end

  // Segments end only on an SCLK fall, so LAT never moves near a rise.
  assign seg_done = sclk_fall && (rise_cnt_q == target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_q        <= 1'b0;
      fc_done_q    <= 1'b0;
      frame_done_q <= 1'b0;
      word_q       <= 4'd0;
      bit_q        <= WORD_BITS - 6'd1;
      rise_cnt_q   <= 6'd0;
      fc_pend_q    <= FC_PEND_RST;
      gs_pend_q    <= 1'b0;
    end else begin
      fc_done_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (sclk_rise) rise_cnt_q <= rise_cnt_q + 6'd1;
      case (state_q)
        IDLE: begin
          if (fc_pend_q) begin
            state_q   <= FC_EN;
            lat_q     <= 1'b1;
            fc_pend_q <= 1'b0;
          end else if (gs_pend_q) begin
            state_q   <= GS_DATA;
            lat_q     <= 1'b0;
            gs_pend_q <= 1'b0;
          end
        end
        FC_EN: if (seg_done) begin
          state_q    <= FC_DATA;
          lat_q      <= 1'b0;
          rise_cnt_q <= 6'd0;
        end
        FC_DATA: if (seg_done) begin
          state_q    <= FC_WR;
          lat_q      <= 1'b1;
          rise_cnt_q <= 6'd0;
        end
        FC_WR: if (seg_done) begin
          state_q    <= IDLE;
          lat_q      <= 1'b0;
          rise_cnt_q <= 6'd0;
          fc_done_q  <= 1'b1;
        end
        GS_DATA: begin
          if (sclk_fall) bit_q <= bit_q - 6'd1;
          if (seg_done) begin
            state_q    <= GS_LAT;
            lat_q      <= 1'b1;
            rise_cnt_q <= 6'd0;
          end
        end
        GS_LAT: begin
          if (sclk_fall) bit_q <= bit_q - 6'd1;
          if (seg_done) begin
            lat_q      <= 1'b0;
            rise_cnt_q <= 6'd0;
            bit_q      <= WORD_BITS - 6'd1;
            if (last_word) begin
              state_q      <= IDLE;
              word_q       <= 4'd0;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= GS_DATA;
              word_q  <= word_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // A request landing in the cycle its flag is consumed still counts.
      if (fc_req)      fc_pend_q <= 1'b1;
      if (frame_start) gs_pend_q <= 1'b1;
    end
  end

  assign LAT         = lat_q;
  assign busy        = run;
  assign gs_shift_en = (state_q == GS_DATA) || (state_q == GS_LAT);
  assign gs_word_idx = word_q;
  assign gs_bit_idx  = bit_q;
  assign fc_done     = fc_done_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_led_band_lat_sequencer.sv
// Bench for led_band_lat_sequencer: LAT level captured at every SCLK rise and
// compared against the command waveform rebuilt from rise counts per command.
module tb_led_band_lat_sequencer;

  localparam int DIV = 2;
  localparam int NW  = 16;

  logic       clk = 1'b0;
  logic       rst, fc_req, frame_start;
  logic       SCLK, LAT, busy, gs_shift_en, fc_done, frame_done;
  logic [3:0] gs_word_idx;
  logic [5:0] gs_bit_idx;

  int checks = 0;
  int errors = 0;

  bit lat_s[$];
  bit shf_s[$];
  int word_s[$];
  int bit_s[$];
  int done_s[$];
  bit exp_lat[$];
  bit sclk_prev = 1'b0;

  led_band_lat_sequencer #(.SCLK_DIV(DIV), .N_WORDS(NW)) dut (
    .clk(clk), .rst(rst), .fc_req(fc_req), .frame_start(frame_start),
    .SCLK(SCLK), .LAT(LAT), .busy(busy), .gs_shift_en(gs_shift_en),
    .gs_word_idx(gs_word_idx), .gs_bit_idx(gs_bit_idx),
    .fc_done(fc_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (SCLK === 1'b1 && sclk_prev == 1'b0) begin
      lat_s.push_back(LAT);
      shf_s.push_back(gs_shift_en);
      word_s.push_back(int'(gs_word_idx));
      bit_s.push_back(int'(gs_bit_idx));
    end
    sclk_prev = (SCLK === 1'b1);
    if (fc_done === 1'b1) done_s.push_back(0);
    if (frame_done === 1'b1) done_s.push_back(1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time_limit_reached");
    $fatal(1, "watchdog");
  end

  function automatic void clear_mon();
    lat_s.delete(); shf_s.delete(); word_s.delete(); bit_s.delete();
    done_s.delete(); exp_lat.delete();
  endfunction

  function automatic void push_run(input bit v, input int n);
    for (int i = 0; i < n; i++) exp_lat.push_back(v);
  endfunction

  // FCWRTEN 15 high, data 43 low, WRTFC 5 high.
  function automatic void exp_fc();
    push_run(1'b1, 15); push_run(1'b0, 43); push_run(1'b1, 5);
  endfunction

  // Each word: 47 low + WRTGS 1 high; last word: 45 low + LATGS 3 high.
  function automatic void exp_frame();
    for (int w = 0; w < NW; w++) begin
      push_run(1'b0, (w == NW - 1) ? 45 : 47);
      push_run(1'b1, (w == NW - 1) ? 3 : 1);
    end
  endfunction

  function automatic int lat_mismatch();
    int n;
    n = (lat_s.size() < exp_lat.size()) ? lat_s.size() : exp_lat.size();
    for (int i = 0; i < n; i++) if (lat_s[i] != exp_lat[i]) return i;
    if (lat_s.size() != exp_lat.size()) return n;
    return -1;
  endfunction

  // Rises from 'base' onward belong to one frame: word r/48, bit 47 - r%48.
  function automatic int idx_mismatch(input int base);
    int bad;
    bad = 0;
    for (int r = 0; r < NW * 48; r++) begin
      if (base + r >= word_s.size()) return bad + 1;
      if (word_s[base + r] != r / 48 || bit_s[base + r] != 47 - (r % 48)
          || shf_s[base + r] != 1'b1) bad++;
    end
    return bad;
  endfunction

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_s.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_fc();
    @(negedge clk); fc_req = 1'b1;
    @(negedge clk); fc_req = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({SCLK, LAT, busy, gs_shift_en, gs_word_idx, gs_bit_idx, fc_done, frame_done}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 6'd47, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s got SCLK=%b LAT=%b busy=%b sh=%b w=%0d b=%0d fd=%b gd=%b exp 0 0 0 0 0 47 0 0",
               tag, SCLK, LAT, busy, gs_shift_en, gs_word_idx, gs_bit_idx, fc_done, frame_done);
    end
  endtask

  task automatic check_lat(input string tag);
    int m;
    m = lat_mismatch();
    checks++;
    if (m !== -1) begin
      errors++;
      $display("FAIL %s first_diff=%0d got_rises=%0d exp_rises=%0d got_lat=%0d exp_lat=%0d", tag, m,
               lat_s.size(), exp_lat.size(), (m < lat_s.size()) ? int'(lat_s[m]) : -1,
               (m < exp_lat.size()) ? int'(exp_lat[m]) : -1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fc_req = 1'b0; frame_start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    clear_mon();
    rst = 1'b0;
  endtask

  task automatic test_auto_fc();
    int first;
    bit ok;
`ifdef LED_SEQ_AUTO_FC_EN
    first = -1;
    for (int i = 1; i <= 2 * DIV + 2; i++) begin
      @(negedge clk);
      if (first < 0 && lat_s.size() > 0) first = i;
    end
    checks++;
    if (first < 0) begin
      errors++;
      $display("FAIL auto_fc_start got no SCLK rise exp within %0d clk", 2 * DIV + 2);
    end
    exp_fc();
    wait_done(1, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL auto_fc_done got timeout exp fc_done"); end
    check_lat("auto_fc_lat");
`else
    first = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || SCLK !== 1'b0) first++;
    end
    checks++;
    if (first != 0) begin
      errors++;
      $display("FAIL no_auto_idle got busy_cycles=%0d exp 0", first);
    end
    ok = 1'b1;
`endif
    repeat (5) @(negedge clk);
  endtask

  task automatic test_fc();
    bit ok;
    int sh;
    clear_mon();
    repeat ($urandom_range(1, 10)) @(negedge clk);
    exp_fc();
    pulse_fc();
    wait_done(1, 400, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL fc_done got timeout exp pulse"); end
    check_lat("fc_lat_pattern");
    checks++;
    if (done_s.size() != 1 || done_s[0] != 0) begin
      errors++;
      $display("FAIL fc_done_events got %0d events exp 1 fc_done", done_s.size());
    end
    sh = 0;
    foreach (shf_s[i]) if (shf_s[i]) sh++;
    checks++;
    if (sh != 0) begin errors++; $display("FAIL fc_shift_en got %0d exp 0", sh); end
    @(negedge clk);
    checks++;
    if ({SCLK, LAT, busy} !== 3'b000) begin
      errors++;
      $display("FAIL fc_after got SCLK=%b LAT=%b busy=%b exp 0 0 0", SCLK, LAT, busy);
    end
  endtask

  task automatic test_frame();
    bit ok;
    int bad;
    clear_mon();
    repeat ($urandom_range(1, 10)) @(negedge clk);
    exp_frame();
    pulse_frame();
    wait_done(1, 3600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL frame_done got timeout exp pulse"); end
    checks++;
    if (lat_s.size() != 768) begin
      errors++;
      $display("FAIL frame_rises got %0d exp 768", lat_s.size());
    end
    check_lat("frame_lat_pattern");
    bad = idx_mismatch(0);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL frame_indices got %0d bad rises exp 0", bad); end
    repeat (3) @(negedge clk);
    checks++;
    if (done_s.size() != 1 || done_s[0] != 1) begin
      errors++;
      $display("FAIL frame_done_events got %0d events exp 1 frame_done", done_s.size());
    end
    checks++;
    if ({gs_word_idx, gs_bit_idx, busy, gs_shift_en} !== {4'd0, 6'd47, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL frame_after got w=%0d b=%0d busy=%b sh=%b exp 0 47 0 0",
               gs_word_idx, gs_bit_idx, busy, gs_shift_en);
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    clear_mon();
    exp_fc();
    exp_frame();
    @(negedge clk); fc_req = 1'b1; frame_start = 1'b1;
    @(negedge clk); fc_req = 1'b0; frame_start = 1'b0;
    wait_done(2, 4200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL simul_done got timeout exp 2 pulses"); end
    check_lat("simul_lat_pattern");
    checks++;
    if (done_s.size() != 2 || done_s[0] != 0 || done_s[1] != 1) begin
      errors++;
      $display("FAIL simul_order got n=%0d first=%0d exp n=2 fc then frame", done_s.size(),
               (done_s.size() > 0) ? done_s[0] : -1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad;
    clear_mon();
    exp_frame();
    exp_frame();
    pulse_frame();
    repeat ($urandom_range(50, 1500)) @(negedge clk);
    pulse_frame();
    repeat ($urandom_range(10, 800)) @(negedge clk);
    pulse_frame();
    wait_done(2, 7500, ok);
    repeat (80) @(negedge clk);
    checks++;
    if (!ok || done_s.size() != 2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_frames got done=%0d busy=%b exp 2 frames then idle", done_s.size(), busy);
    end
    check_lat("b2b_lat_pattern");
    bad = idx_mismatch(768);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_indices got %0d bad rises exp 0", bad); end
  endtask

  task automatic test_rst_mid();
    bit ok;
    clear_mon();
    pulse_fc();
    pulse_frame();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (lat_s.size() >= 35) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || lat_s[14] != 1'b1 || lat_s[34] != 1'b0) begin
      errors++;
      $display("FAIL rst_mid_reach got rises=%0d exp 35 with FC_DATA low", lat_s.size());
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid_values");
    clear_mon();
    exp_fc();
    rst = 1'b0;
`ifndef LED_SEQ_AUTO_FC_EN
    pulse_fc();
`endif
    wait_done(1, 400, ok);
    repeat (60) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_fc_done got timeout exp pulse"); end
    check_lat("rst_fc_lat_pattern");
    checks++;
    if (done_s.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_pending_lost got done=%0d busy=%b exp 1 0", done_s.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_auto_fc();
    test_fc();
    test_frame();
    test_simultaneous();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_band_lat_sequencer.md
Name: led_band_lat_sequencer

Overview:
- Command sequencer directly upstream of the LED-band FC setter and GS serializer for one TLC5957-style driver chain.
- Generates the SCLK/LAT waveforms for three commands:
  - FCWRTEN: 15 SCLK rises with LAT high.
  - WRTFC: 5 SCLK rises with LAT high.
  - WRTGS/LATGS: 1 or 3 SCLK rises with LAT high.
- Enforces exactly 48 SCLK rises from the LAT fall after FCWRTEN to the LAT fall after WRTFC.
- Tells the GS data source which word and bit are being shifted.

Parameters:
- SCLK_DIV, 2: clk cycles per SCLK half-period. Legal range 2..255; must be ≥2 so downstream edge detection on clk works.
- N_WORDS, 16: 48-bit GS words per frame. Legal range 1..16.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- fc_req  in  1  one-clk pulse; run FC write sequence
- frame_start  in  1  one-clk pulse; run one GS frame
- SCLK  out  1  driver shift clock
- LAT  out  1  driver latch/command line
- busy  out  1  high whenever state ≠ IDLE
- gs_shift_en  out  1  high while GS bits are being shifted
- gs_word_idx  out  4  current GS word, 0..N_WORDS-1
- gs_bit_idx  out  6  current bit, 47 down to 0, MSB first
- fc_done  out  1  one-clk pulse when the FC sequence ends
- frame_done  out  1  one-clk pulse when a GS frame ends

Behaviour:
- Reset values:
  - Outputs: SCLK=0, LAT=0, busy=0, gs_shift_en=0, gs_word_idx=0, gs_bit_idx=47, fc_done=0, frame_done=0.
  - Internal: state=IDLE, pending flags cleared.
- SCLK generation:
  - The divider runs only when state ≠ IDLE.
  - SCLK toggles every SCLK_DIV clk cycles; the first toggle after leaving IDLE is a rising edge.
  - In IDLE, SCLK is held low.
- Edge counting and LAT timing:
  - Internal rise_cnt[5:0] increments on each SCLK rise (clk cycle where SCLK goes 0→1).
  - LAT and the state change only in the clk cycle where SCLK goes 1→0. LAT is therefore stable for a half-period around each rise.
- Request latching:
  - fc_req and frame_start each set a one-deep pending flag. A duplicate while the flag is already pending is dropped.
  - Requests arriving while busy are kept pending.
- IDLE arbitration: FC pending wins over GS pending. Pending flags clear on entry to the selected sequence.
- FC sequence states:
  - FC_EN: LAT=1 for 15 rises.
  - FC_DATA: LAT=0 for 43 rises.
  - FC_WR: LAT=1 for 5 rises.
  - Then IDLE with LAT=0 and fc_done pulsed.
  - FC_DATA plus FC_WR total exactly 48 rises.
- GS sequence, per word w:
  - GS_DATA: LAT=0 for 47 rises, or 45 if w=N_WORDS-1.
  - GS_LAT: LAT=1 for 1 rise (WRTGS), or 3 (LATGS) on the last word.
  - gs_shift_en=1 across GS_DATA and GS_LAT.
  - gs_bit_idx decrements at each SCLK fall. It reloads to 47 and gs_word_idx increments when the word finishes.
  - After the last word: IDLE, frame_done pulsed, gs_word_idx=0, gs_bit_idx=47.
- Exit conditions:
  - After every sequence, SCLK returns low and the block spends ≥1 clk in IDLE before the next sequence.
  - A LAT-low clk cycle therefore always follows each LAT fall.
- Boundary cases:
  - fc_req and frame_start in the same cycle: both pend; FC runs first, then GS.
  - N_WORDS=1: a single 45+3 LATGS word.
  - rst mid-sequence: immediate return to reset values and all pending requests lost. The next sequence starts with a fresh FCWRTEN count.
- Width rules: rise_cnt compares against constants ≤47; gs_word_idx wraps only via explicit reload.

Optional Feature:
- Macro: LED_SEQ_AUTO_FC_EN
- Defined: reset sets the FC pending flag. The first sequence after reset deassertion is the FC sequence, with no fc_req needed.
- Undefined: nothing runs until fc_req or frame_start.

Decomposition:
- Package led_band_pkg:
  - State enum: IDLE, FC_EN, FC_DATA, FC_WR, GS_DATA, GS_LAT.
  - Command rise-count constants: FCWRTEN_RISES=15, WRTFC_RISES=5, WRTGS_RISES=1, LATGS_RISES=3, WORD_BITS=48.
- Sub-module led_band_sclk_gen: divider plus rise/fall strobes, gated by a run input.

Test Plan:
- Reset, then fc_req, SCLK_DIV=2 → LAT high for exactly 15 rises, low for 43, high for 5; fc_done pulse; SCLK low afterward. Bench FC setter en returns to 1.
- frame_start, N_WORDS=16:
  - Words 0–14 show 47 low + 1 high rises each.
  - Word 15 shows 45 low + 3 high.
  - 768 rises total; frame_done pulses once; indices return to 0/47.
- fc_req and frame_start in the same cycle → FC sequence completes first, GS frame follows, both done pulses appear in order.
- frame_start asserted twice during a running frame → exactly one additional frame runs.
- rst asserted at rise 20 of FC_DATA → all outputs at reset values next cycle. A subsequent fc_req produces a full 15/43/5 sequence.
- LED_SEQ_AUTO_FC_EN defined, no requests → FC sequence starts within 2·SCLK_DIV+2 clk of rst deassertion. Undefined → busy stays 0.
